// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared parameters, word-width helper and master state encoding for the 1-bit RAM
package ram_pkg;

  localparam int ADDR_W           = 2;
  localparam int READ_LATENCY     = 1;
  localparam int MAX_READ_LATENCY = 3;

  function automatic int width_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } ram_master_state_t;

endpackage

// File: rtl/ram_bus_tristate.sv
// rtl/ram_bus_tristate.sv - single-bit tristate driver for the shared RAM data wire
module ram_bus_tristate (
  input  logic oe,
  input  logic dout,
  output logic din,
  inout  wire  pad
);

  assign pad = oe ? dout : 1'bz;
  assign din = pad;

endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - serialises 4-bit host words into 1-bit RAM accesses over a shared data wire
module ram_master
  import ram_pkg::*;
#(
  parameter int ADDR_W       = ram_pkg::ADDR_W,
  parameter int READ_LATENCY = ram_pkg::READ_LATENCY,
  localparam int WIDTH       = width_of(ADDR_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  inout  wire               ram_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WIDTH - 1);
  localparam logic [1:0]        LAST_WAIT =
    2'((READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY);

  ram_master_state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              req_ready_q, req_ready_d;
  logic              bus_din;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          is_write_d = req_write;
          wdata_d    = req_wdata;
          idx_d      = '0;
          wcnt_d     = '0;
          buf_d      = '0;
          state_d    = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      READ: begin
        // Data is only valid on the last cycle each address is held.
        if (wcnt_q == LAST_WAIT) begin
          buf_d[idx_q] = bus_din;
          wcnt_d       = '0;
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      buf_q       <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      buf_q       <= buf_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = ((state_q == DONE) && !is_write_q) ? buf_q : '0;
  assign ram_address = idx_q;
  assign ram_we      = (state_q == WRITE);

  // Drive enable is the write strobe itself, so the RAM and master can never overlap.
  ram_bus_tristate u_bus (
    .oe   (state_q == WRITE),
    .dout (wdata_q[idx_q]),
    .din  (bus_din),
    .pad  (ram_data)
  );

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - bench for ram_master with latency-1 and latency-3 RAM models on the bus
module tb_ram_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       req_valid [2];
  logic       req_write;
  logic [3:0] req_wdata;
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [3:0] rsp_rdata [2];
  logic [1:0] ram_address [2];
  logic       ram_we [2];
  wire        ram_data0;
  wire        ram_data1;

  ram_master #(.READ_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .ram_address(ram_address[0]), .ram_we(ram_we[0]),
    .ram_data(ram_data0)
  );

  ram_master #(.READ_LATENCY(3)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .ram_address(ram_address[1]), .ram_we(ram_we[1]),
    .ram_data(ram_data1)
  );

  // RAM models: read data reflects the address presented L cycles earlier.
  logic [3:0] mem0 = 4'b0101;
  logic [3:0] mem1 = 4'b1100;
  logic [1:0] ahist0 = 2'd0;
  logic [1:0] ahist1 [3] = '{2'd0, 2'd0, 2'd0};
  logic ram_q0, ram_q1;

  always @(posedge clock) begin
    if (ram_we[0]) mem0[ram_address[0]] <= ram_data0;
    if (ram_we[1]) mem1[ram_address[1]] <= ram_data1;
    ahist0    <= ram_address[0];
    ahist1[0] <= ram_address[1];
    ahist1[1] <= ahist1[0];
    ahist1[2] <= ahist1[1];
  end

  assign ram_q0    = mem0[ahist0];
  assign ram_q1    = mem1[ahist1[2]];
  assign ram_data0 = ram_we[0] ? 1'bz : ram_q0;
  assign ram_data1 = ram_we[1] ? 1'bz : ram_q1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] model_word [2] = '{4'b0101, 4'b1100};
  time prev_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bus(input int w);
    return (w == 0) ? ram_data0 : ram_data1;
  endfunction

  // When the master is not strobing, the wire must carry exactly what the RAM drives.
  always @(negedge clock) begin
    if (!ram_we[0]) check("bus0_no_master_drive", ram_data0, ram_q0);
    if (!ram_we[1]) check("bus1_no_master_drive", ram_data1, ram_q1);
  end

  // Called at a negedge with DUT w idle; returns at the negedge after rsp (plus one idle cycle if !hold).
  task automatic run_op(input int w, input logic wr, input logic [3:0] wd, input logic [3:0] exp,
                        input bit hold, input bit noise, input int exp_gap);
    int   lat = (w == 0) ? 1 : 3;
    int   t   = wr ? 4 : 4 * (lat + 1);
    int   a;
    bit   got = 0;
    req_write    = wr;
    req_wdata    = wd;
    req_valid[w] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[w] === 1'b1) begin got = 1; break; end
      @(negedge clock);
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid[w] = 1'b0;
      return;
    end
    @(posedge clock);
    if (exp_gap != 0) check("req_gap", 32'(($time - prev_hs) / 10), 32'(exp_gap));
    prev_hs = $time;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clock);
      if (k == 1 && !hold) req_valid[w] = 1'b0;
      if (noise && k >= 2 && k <= 6) begin
        req_valid[w] = k[0];
        req_write    = 1'b1;
        req_wdata    = 4'($urandom);
      end
      if (noise && k == 7) req_valid[w] = 1'b0;
      if (k <= t) begin
        a = wr ? (k - 1) : ((k - 1) / (lat + 1));
        check("access", {ram_we[w], ram_address[w], rsp_valid[w]}, {wr, 2'(a), 1'b0});
        if (wr) check("write_bit", bus(w), wd[a]);
      end else begin
        check("response", {rsp_valid[w], rsp_rdata[w]}, {1'b1, exp});
      end
    end
    if (wr) model_word[w] = wd;
    if (!hold) begin
      @(negedge clock);
      check("back_to_idle", {rsp_valid[w], req_ready[w]}, 2'b01);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] wd;
    logic [3:0] exp;
    bit         hold;
    int         gap;
  } vec_t;

  initial begin
    vec_t       vecs [6];
    int         w;
    logic       wr;
    logic [3:0] wd;

    vecs[0] = '{1'b1, 4'b1011, 4'b0000, 1'b0, 0};
    vecs[1] = '{1'b0, 4'b0000, 4'b1011, 1'b0, 0};
    vecs[2] = '{1'b1, 4'b0110, 4'b0000, 1'b1, 0};
    vecs[3] = '{1'b0, 4'b0000, 4'b0110, 1'b1, 6};
    vecs[4] = '{1'b1, 4'b1001, 4'b0000, 1'b1, 10};
    vecs[5] = '{1'b0, 4'b0000, 4'b1001, 1'b0, 6};

    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    req_write    = 1'b0;
    req_wdata    = 4'd0;
    prev_hs      = 0;

    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++)
      check("reset_state", {req_ready[i], rsp_valid[i], rsp_rdata[i], ram_address[i], ram_we[i]}, 9'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset0", req_ready[0], 1'b1);
    check("ready_after_reset1", req_ready[1], 1'b1);

    for (int i = 0; i < 6; i++)
      run_op(0, vecs[i].wr, vecs[i].wd, vecs[i].exp, vecs[i].hold, 1'b0, vecs[i].gap);

    // Busy read with a competing request toggling on the host port.
    run_op(0, 1'b0, 4'b0000, model_word[0], 1'b0, 1'b1, 0);

    // Reset during the second bit of a write: bits 0..1 land, 2..3 keep old contents.
    req_write    = 1'b1;
    req_wdata    = 4'b0100;
    req_valid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    check("abort_cycle1", {ram_we[0], ram_address[0]}, {1'b1, 2'd0});
    @(negedge clock);
    check("abort_cycle2", {ram_we[0], ram_address[0]}, {1'b1, 2'd1});
    reset = 1'b1;
    @(negedge clock);
    check("abort_released", {ram_we[0], ram_address[0], rsp_valid[0]}, 4'd0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready", {req_ready[0], rsp_valid[0]}, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("abort_no_rsp", rsp_valid[0], 1'b0);
    end
    model_word[0] = 4'b1000;
    run_op(0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 0);

    run_op(1, 1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0, 0);
    run_op(1, 1'b0, 4'b0000, 4'b1011, 1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      w  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = 4'($urandom);
      run_op(w, wr, wd, wr ? 4'b0000 : model_word[w], 1'b0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
